// File: rtl/rf_wb_if.sv
// Write-side bundle between execute/LSU/decode and the register-file writeback arbiter.
// master = the surrounding pipeline, slave = the arbiter.
interface rf_wb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            alu_wb_valid;
  logic [AW-1:0]   alu_wb_rd;
  logic [XLEN-1:0] alu_wb_data;
  // MEM stream: a transfer happens on a posedge where mem_wb_valid & mem_wb_ready;
  // while valid & !ready the producer holds mem_wb_rd/mem_wb_data stable.
  logic            mem_wb_valid;
  logic            mem_wb_ready;
  logic [AW-1:0]   mem_wb_rd;
  logic [XLEN-1:0] mem_wb_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            hazard_rs1;
  logic            hazard_rs2;
  logic            rf_we;
  logic [AW-1:0]   rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic            hold_full;

  modport master (
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    output mem_wb_valid, mem_wb_rd, mem_wb_data,
    output issue_valid, issue_rd, rs1, rs2,
    input  mem_wb_ready, hazard_rs1, hazard_rs2,
    input  rf_we, rf_wa, rf_wd, hold_full
  );

  modport slave (
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  mem_wb_valid, mem_wb_rd, mem_wb_data,
    input  issue_valid, issue_rd, rs1, rs2,
    output mem_wb_ready, hazard_rs1, hazard_rs2,
    output rf_we, rf_wa, rf_wd, hold_full
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Merges the ALU and MEM writeback streams onto the single register-file write port,
// with a one-entry hold buffer for MEM results and a pending scoreboard for RAW stalls.
module rf_writeback_arbiter #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input logic   clk,
  input logic   reset_n,
  rf_wb_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} hold_state_t;

  hold_state_t     state, state_nx;
  logic [AW-1:0]   held_rd;
  logic [XLEN-1:0] held_data;
  logic [NREGS-1:0] pending, pending_nx, set_mask, clr_mask;

  logic            mem_xfer, capture;
  logic            sel_valid, clr_valid;
  logic [AW-1:0]   sel_rd, clr_rd;
  logic [XLEN-1:0] sel_data;

  assign bus.mem_wb_ready = (state == EMPTY);
  assign bus.hold_full    = (state == FULL);
  assign mem_xfer         = bus.mem_wb_valid & (state == EMPTY);

  // Priority: ALU, then held entry, then a fresh MEM transfer.
  always_comb begin
    state_nx  = state;
    capture   = 1'b0;
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    clr_valid = 1'b0;
    clr_rd    = '0;
    case (state)
      EMPTY: begin
        if (bus.alu_wb_valid) begin
          sel_valid = 1'b1;
          sel_rd    = bus.alu_wb_rd;
          sel_data  = bus.alu_wb_data;
          if (mem_xfer) begin
            // MEM result already overwritten by a younger ALU write: drop it.
            if (bus.alu_wb_rd == bus.mem_wb_rd && bus.alu_wb_rd != '0) begin
              clr_valid = 1'b1;
              clr_rd    = bus.mem_wb_rd;
            end else begin
              capture  = 1'b1;
              state_nx = FULL;
            end
          end
        end else if (mem_xfer) begin
          sel_valid = 1'b1;
          sel_rd    = bus.mem_wb_rd;
          sel_data  = bus.mem_wb_data;
          clr_valid = 1'b1;
          clr_rd    = bus.mem_wb_rd;
        end
      end
      FULL: begin
        if (bus.alu_wb_valid) begin
          sel_valid = 1'b1;
          sel_rd    = bus.alu_wb_rd;
          sel_data  = bus.alu_wb_data;
          if (bus.alu_wb_rd == held_rd && held_rd != '0) begin
            clr_valid = 1'b1;
            clr_rd    = held_rd;
            state_nx  = EMPTY;
          end
        end else begin
          sel_valid = 1'b1;
          sel_rd    = held_rd;
          sel_data  = held_data;
          clr_valid = 1'b1;
          clr_rd    = held_rd;
          state_nx  = EMPTY;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // Set beats clear for the same register; x0 never pends.
  always_comb begin
    set_mask   = '0;
    clr_mask   = '0;
    if (bus.issue_valid) set_mask[bus.issue_rd] = 1'b1;
    if (clr_valid)       clr_mask[clr_rd]       = 1'b1;
    pending_nx    = (pending & ~clr_mask) | set_mask;
    pending_nx[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= EMPTY;
      pending <= '0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      held_rd   <= '0;
      held_data <= '0;
    end else if (capture) begin
      held_rd   <= bus.mem_wb_rd;
      held_data <= bus.mem_wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.rf_we <= 1'b0;
      bus.rf_wa <= '0;
      bus.rf_wd <= '0;
    end else begin
      bus.rf_we <= sel_valid & (sel_rd != '0);
      if (sel_valid) begin
        bus.rf_wa <= sel_rd;
        bus.rf_wd <= sel_data;
      end
    end
  end

  assign bus.hazard_rs1 = (bus.rs1 != '0) &
                          (pending[bus.rs1] | ((state == FULL) & (held_rd == bus.rs1)));
  assign bus.hazard_rs2 = (bus.rs2 != '0) &
                          (pending[bus.rs2] | ((state == FULL) & (held_rd == bus.rs2)));
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: each task drives one scenario and checks
// hand-computed results of the write port, handshake and hazard outputs.
module tb_rf_writeback_arbiter;
  logic clk;
  logic reset_n;
  int   chk_cnt;
  int   pass_cnt;

  rf_wb_if #(.XLEN(32), .AW(5)) bus ();

  rf_writeback_arbiter #(.XLEN(32), .NREGS(32), .AW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_wb_valid = 1'b0;
    bus.alu_wb_rd    = '0;
    bus.alu_wb_data  = '0;
    bus.mem_wb_valid = 1'b0;
    bus.mem_wb_rd    = '0;
    bus.mem_wb_data  = '0;
    bus.issue_valid  = 1'b0;
    bus.issue_rd     = '0;
    bus.rs1          = '0;
    bus.rs2          = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
    bus.alu_wb_valid = 1'b1;
    bus.alu_wb_rd    = rd;
    bus.alu_wb_data  = data;
  endtask

  task automatic drive_mem(input logic [4:0] rd, input logic [31:0] data);
    bus.mem_wb_valid = 1'b1;
    bus.mem_wb_rd    = rd;
    bus.mem_wb_data  = data;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd5; bus.alu_wb_data = 32'hAAAA_5555;
    bus.mem_wb_valid = 1'b1; bus.mem_wb_rd = 5'd6; bus.mem_wb_data = 32'h1234_5678;
    bus.issue_valid  = 1'b1; bus.issue_rd  = 5'd5;
    bus.rs1 = 5'd5; bus.rs2 = 5'd6;
    step();
    step();
    chk_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL reset_we: got %0b want 0", bus.rf_we); else pass_cnt++;
    chk_cnt++; if (bus.rf_wa !== 5'd0) $display("FAIL reset_wa: got %0d want 0", bus.rf_wa); else pass_cnt++;
    chk_cnt++; if (bus.rf_wd !== 32'h0) $display("FAIL reset_wd: got %h want 0", bus.rf_wd); else pass_cnt++;
    chk_cnt++; if (bus.mem_wb_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", bus.mem_wb_ready); else pass_cnt++;
    chk_cnt++; if ({bus.hazard_rs1, bus.hazard_rs2} !== 2'b00) $display("FAIL reset_hazard: got %b want 00", {bus.hazard_rs1, bus.hazard_rs2}); else pass_cnt++;
    reset_n = 1'b1;
    idle();
    step();
    chk_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL post_reset_we: got %0b want 0", bus.rf_we); else pass_cnt++;
  endtask

  task automatic test_alu_only();
    drive_alu(5'd5, 32'hDEAD_BEEF);
    step();
    idle();
    chk_cnt++; if (bus.rf_we !== 1'b1) $display("FAIL alu_we: got %0b want 1", bus.rf_we); else pass_cnt++;
    chk_cnt++; if (bus.rf_wa !== 5'd5) $display("FAIL alu_wa: got %0d want 5", bus.rf_wa); else pass_cnt++;
    chk_cnt++; if (bus.rf_wd !== 32'hDEAD_BEEF) $display("FAIL alu_wd: got %h want deadbeef", bus.rf_wd); else pass_cnt++;
    step();
    chk_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL alu_idle_we: got %0b want 0", bus.rf_we); else pass_cnt++;
    chk_cnt++; if (bus.rf_wd !== 32'hDEAD_BEEF) $display("FAIL alu_idle_hold_wd: got %h want deadbeef", bus.rf_wd); else pass_cnt++;
  endtask

  task automatic test_collision();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    step();
    idle();
    bus.rs1 = 5'd7;
    #1;
    chk_cnt++; if (bus.hazard_rs1 !== 1'b1) $display("FAIL coll_issue_hazard: got %0b want 1", bus.hazard_rs1); else pass_cnt++;
    drive_alu(5'd3, 32'h11);
    drive_mem(5'd7, 32'h22);
    #1;
    chk_cnt++; if (bus.mem_wb_ready !== 1'b1) $display("FAIL coll_ready_before: got %0b want 1", bus.mem_wb_ready); else pass_cnt++;
    step();
    idle();
    bus.rs1 = 5'd7;
    #1;
    chk_cnt++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 5'd3, 32'h11}) $display("FAIL coll_alu_write: got we=%0b wa=%0d wd=%h want we=1 wa=3 wd=11", bus.rf_we, bus.rf_wa, bus.rf_wd); else pass_cnt++;
    chk_cnt++; if (bus.mem_wb_ready !== 1'b0) $display("FAIL coll_ready_full: got %0b want 0", bus.mem_wb_ready); else pass_cnt++;
    chk_cnt++; if (bus.hazard_rs1 !== 1'b1) $display("FAIL coll_held_hazard: got %0b want 1", bus.hazard_rs1); else pass_cnt++;
    step();
    chk_cnt++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 5'd7, 32'h22}) $display("FAIL coll_mem_write: got we=%0b wa=%0d wd=%h want we=1 wa=7 wd=22", bus.rf_we, bus.rf_wa, bus.rf_wd); else pass_cnt++;
    chk_cnt++; if (bus.mem_wb_ready !== 1'b1) $display("FAIL coll_ready_drain: got %0b want 1", bus.mem_wb_ready); else pass_cnt++;
    chk_cnt++; if (bus.hazard_rs1 !== 1'b0) $display("FAIL coll_pending_clear: got %0b want 0", bus.hazard_rs1); else pass_cnt++;
  endtask

  task automatic test_stale_drop();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    step();
    idle();
    drive_alu(5'd2, 32'h01);
    drive_mem(5'd9, 32'h99);
    step();
    idle();
    chk_cnt++; if (bus.hold_full !== 1'b1) $display("FAIL stale_full: got %0b want 1", bus.hold_full); else pass_cnt++;
    drive_alu(5'd9, 32'h55);
    step();
    idle();
    bus.rs1 = 5'd9;
    #1;
    chk_cnt++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 5'd9, 32'h55}) $display("FAIL stale_alu_write: got we=%0b wa=%0d wd=%h want we=1 wa=9 wd=55", bus.rf_we, bus.rf_wa, bus.rf_wd); else pass_cnt++;
    chk_cnt++; if (bus.hold_full !== 1'b0) $display("FAIL stale_empty: got %0b want 0", bus.hold_full); else pass_cnt++;
    chk_cnt++; if (bus.hazard_rs1 !== 1'b0) $display("FAIL stale_hazard: got %0b want 0", bus.hazard_rs1); else pass_cnt++;
    step();
    chk_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL stale_no_old_write: got %0b want 0", bus.rf_we); else pass_cnt++;
  endtask

  task automatic test_capture_drop();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd10;
    step();
    idle();
    drive_alu(5'd10, 32'hA0A0);
    drive_mem(5'd10, 32'hB0B0);
    step();
    idle();
    bus.rs2 = 5'd10;
    #1;
    chk_cnt++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 5'd10, 32'hA0A0}) $display("FAIL capdrop_write: got we=%0b wa=%0d wd=%h want we=1 wa=10 wd=a0a0", bus.rf_we, bus.rf_wa, bus.rf_wd); else pass_cnt++;
    chk_cnt++; if (bus.mem_wb_ready !== 1'b1) $display("FAIL capdrop_ready: got %0b want 1", bus.mem_wb_ready); else pass_cnt++;
    chk_cnt++; if (bus.hazard_rs2 !== 1'b0) $display("FAIL capdrop_hazard: got %0b want 0", bus.hazard_rs2); else pass_cnt++;
    step();
    chk_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL capdrop_no_write: got %0b want 0", bus.rf_we); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    idle();
    drive_alu(5'd1, 32'h101);
    drive_mem(5'd14, 32'hE14);
    step();
    idle();
    drive_alu(5'd2, 32'h202);
    bus.rs1 = 5'd14;
    #1;
    chk_cnt++; if (bus.hazard_rs1 !== 1'b1) $display("FAIL b2b_held_hazard: got %0b want 1", bus.hazard_rs1); else pass_cnt++;
    chk_cnt++; if ({bus.rf_wa, bus.rf_wd} !== {5'd1, 32'h101}) $display("FAIL b2b_w1: got wa=%0d wd=%h want wa=1 wd=101", bus.rf_wa, bus.rf_wd); else pass_cnt++;
    step();
    drive_alu(5'd3, 32'h303);
    chk_cnt++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd, bus.mem_wb_ready} !== {1'b1, 5'd2, 32'h202, 1'b0}) $display("FAIL b2b_w2: got we=%0b wa=%0d wd=%h rdy=%0b want we=1 wa=2 wd=202 rdy=0", bus.rf_we, bus.rf_wa, bus.rf_wd, bus.mem_wb_ready); else pass_cnt++;
    step();
    idle();
    chk_cnt++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 5'd3, 32'h303}) $display("FAIL b2b_w3: got we=%0b wa=%0d wd=%h want we=1 wa=3 wd=303", bus.rf_we, bus.rf_wa, bus.rf_wd); else pass_cnt++;
    step();
    chk_cnt++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 5'd14, 32'hE14}) $display("FAIL b2b_held_write: got we=%0b wa=%0d wd=%h want we=1 wa=14 wd=e14", bus.rf_we, bus.rf_wa, bus.rf_wd); else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
    step();
    idle();
    bus.rs2 = 5'd12;
    #1;
    chk_cnt++; if (bus.hazard_rs2 !== 1'b1) $display("FAIL sb_set: got %0b want 1", bus.hazard_rs2); else pass_cnt++;
    step();
    step();
    chk_cnt++; if (bus.hazard_rs2 !== 1'b1) $display("FAIL sb_hold: got %0b want 1", bus.hazard_rs2); else pass_cnt++;
    drive_mem(5'd12, 32'hC12);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
    step();
    idle();
    bus.rs2 = 5'd12;
    #1;
    chk_cnt++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 5'd12, 32'hC12}) $display("FAIL sb_mem_write: got we=%0b wa=%0d wd=%h want we=1 wa=12 wd=c12", bus.rf_we, bus.rf_wa, bus.rf_wd); else pass_cnt++;
    chk_cnt++; if (bus.hazard_rs2 !== 1'b1) $display("FAIL sb_set_wins: got %0b want 1", bus.hazard_rs2); else pass_cnt++;
    drive_mem(5'd12, 32'hC13);
    step();
    idle();
    bus.rs2 = 5'd12;
    #1;
    chk_cnt++; if (bus.hazard_rs2 !== 1'b0) $display("FAIL sb_clear: got %0b want 0", bus.hazard_rs2); else pass_cnt++;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    step();
    idle();
    step();
    chk_cnt++; if ({bus.hazard_rs1, bus.hazard_rs2} !== 2'b00) $display("FAIL sb_x0: got %b want 00", {bus.hazard_rs1, bus.hazard_rs2}); else pass_cnt++;
  endtask

  task automatic test_x0_and_reset();
    idle();
    drive_mem(5'd0, 32'h77);
    #1;
    chk_cnt++; if (bus.mem_wb_ready !== 1'b1) $display("FAIL x0_ready: got %0b want 1", bus.mem_wb_ready); else pass_cnt++;
    step();
    idle();
    chk_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL x0_we: got %0b want 0", bus.rf_we); else pass_cnt++;
    chk_cnt++; if (bus.mem_wb_ready !== 1'b1) $display("FAIL x0_ready_after: got %0b want 1", bus.mem_wb_ready); else pass_cnt++;
    drive_alu(5'd4, 32'h44);
    drive_mem(5'd6, 32'h66);
    step();
    idle();
    chk_cnt++; if (bus.mem_wb_ready !== 1'b0) $display("FAIL midrst_full: got %0b want 0", bus.mem_wb_ready); else pass_cnt++;
    reset_n = 1'b0;
    step();
    chk_cnt++; if ({bus.rf_we, bus.rf_wa, bus.mem_wb_ready} !== {1'b0, 5'd0, 1'b1}) $display("FAIL midrst_reset: got we=%0b wa=%0d rdy=%0b want we=0 wa=0 rdy=1", bus.rf_we, bus.rf_wa, bus.mem_wb_ready); else pass_cnt++;
    reset_n = 1'b1;
    step();
    chk_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL midrst_no_held: got %0b want 0", bus.rf_we); else pass_cnt++;
    step();
    chk_cnt++; if (bus.rf_we !== 1'b0) $display("FAIL midrst_no_held2: got %0b want 0", bus.rf_we); else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    reset_n  = 1'b0;
    idle();
    test_reset();
    test_alu_only();
    test_collision();
    test_stale_drop();
    test_capture_drop();
    test_back_to_back();
    test_scoreboard();
    test_x0_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
